// File: rtl/vga_layer_compositor.sv
// vga_layer_compositor
// VGA timing generator plus a fixed-priority multi-layer pixel compositor.
// A clock divider produces the pixel strobe. The h/v counters walk the
// full raster, and pixel_x/pixel_y come straight from them so that the
// layer generators can answer combinationally for the current coordinate.
// Each pixel_tick registers the composite colour, the visible flag and both
// sync levels for the current coordinate. Every pin is therefore exactly
// one pixel behind pixel_x/pixel_y, and all pins stay mutually aligned.
// A frame counter drives a blink phase. While the phase is high, it masks
// every layer that has blink enabled.
module vga_layer_compositor #(
    parameter int COLOR_W      = 3,
    parameter int N_LAYERS     = 4,
    parameter int DIV          = 4,
    parameter int H_DISPLAY    = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_DISPLAY    = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                          clk_100MHz,
    input  logic                          reset,
    input  logic [N_LAYERS-1:0]           layer_on,
    input  logic [N_LAYERS*COLOR_W-1:0]   layer_rgb,
    input  logic [N_LAYERS-1:0]           blink_en,
    input  logic [COLOR_W-1:0]            bg_rgb,
    output logic [9:0]                    pixel_x,
    output logic [9:0]                    pixel_y,
    output logic                          pixel_tick,
    output logic                          frame_start,
    output logic                          hsync,
    output logic                          vsync,
    output logic                          video_on,
    output logic [COLOR_W-1:0]            rgb
);

    localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int FC_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(DIV - 1);
    localparam logic [FC_W-1:0]  FC_LAST      = FC_W'(BLINK_FRAMES - 1);
    localparam logic [9:0]       H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0]       H_VIS_END    = 10'(H_DISPLAY);
    localparam logic [9:0]       V_VIS_END    = 10'(V_DISPLAY);
    localparam logic [9:0]       H_SYNC_START = 10'(H_DISPLAY + H_FP);
    localparam logic [9:0]       H_SYNC_END   = 10'(H_DISPLAY + H_FP + H_SYNC);
    localparam logic [9:0]       V_SYNC_START = 10'(V_DISPLAY + V_FP);
    localparam logic [9:0]       V_SYNC_END   = 10'(V_DISPLAY + V_FP + V_SYNC);

    // Raster state
    logic [DIV_W-1:0]   div_r;
    logic [DIV_W-1:0]   div_nxt_s;
    logic [9:0]         h_r;
    logic [9:0]         v_r;
    logic [9:0]         h_nxt_s;
    logic [9:0]         v_nxt_s;
    logic               pixel_tick_r;
    logic               frame_start_r;
    logic               tick_nxt_s;
    logic               frame_nxt_s;

    // Blink state
    logic [FC_W-1:0]    frame_cnt_r;
    logic               blink_phase_r;

    // Composite path
    logic [N_LAYERS-1:0] eff_on_s;
    logic [COLOR_W-1:0]  layer_pix_s;
    logic [COLOR_W-1:0]  rgb_nxt_s;
    logic                visible_s;
    logic                hsync_nxt_s;
    logic                vsync_nxt_s;

    // Output registers
    logic [COLOR_W-1:0]  rgb_r;
    logic                video_on_r;
    logic                hsync_r;
    logic                vsync_r;

    // Next divider and raster position. The tick strobe and frame strobe are
    // registered from the next state, so each one lines up with the cycle it
    // describes.
    always_comb begin
        div_nxt_s = div_r;
        h_nxt_s   = h_r;
        v_nxt_s   = v_r;
        if (div_r == DIV_LAST) begin
            div_nxt_s = '0;
        end else begin
            div_nxt_s = div_r + DIV_W'(1);
        end
        if (pixel_tick_r) begin
            if (h_r == H_LAST) begin
                h_nxt_s = 10'd0;
                if (v_r == V_LAST) begin
                    v_nxt_s = 10'd0;
                end else begin
                    v_nxt_s = v_r + 10'd1;
                end
            end else begin
                h_nxt_s = h_r + 10'd1;
                v_nxt_s = v_r;
            end
        end else begin
            h_nxt_s = h_r;
            v_nxt_s = v_r;
        end
        tick_nxt_s  = (div_nxt_s == DIV_LAST);
        frame_nxt_s = tick_nxt_s && (h_nxt_s == H_LAST) && (v_nxt_s == V_LAST);
    end

    // Divider, raster counters and their strobes
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            div_r         <= '0;
            h_r           <= 10'd0;
            v_r           <= 10'd0;
            pixel_tick_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            div_r         <= div_nxt_s;
            h_r           <= h_nxt_s;
            v_r           <= v_nxt_s;
            pixel_tick_r  <= tick_nxt_s;
            frame_start_r <= frame_nxt_s;
        end
    end

    // Blink phase toggles every BLINK_FRAMES frames. The update happens at
    // the last pixel edge, so the new phase first applies at pixel (0,0).
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            frame_cnt_r   <= '0;
            blink_phase_r <= 1'b0;
        end else if (frame_start_r) begin
            if (frame_cnt_r == FC_LAST) begin
                frame_cnt_r   <= '0;
                blink_phase_r <= ~blink_phase_r;
            end else begin
                frame_cnt_r   <= frame_cnt_r + FC_W'(1);
                blink_phase_r <= blink_phase_r;
            end
        end else begin
            frame_cnt_r   <= frame_cnt_r;
            blink_phase_r <= blink_phase_r;
        end
    end

    // Composite colour for the current h/v. The scan runs from the lowest
    // priority upward, so the lowest active index is the last one written.
    always_comb begin
        visible_s   = (h_r < H_VIS_END) && (v_r < V_VIS_END);
        hsync_nxt_s = !((h_r >= H_SYNC_START) && (h_r < H_SYNC_END));
        vsync_nxt_s = !((v_r >= V_SYNC_START) && (v_r < V_SYNC_END));
        eff_on_s    = layer_on & ~(blink_en & {N_LAYERS{blink_phase_r}});
        layer_pix_s = bg_rgb;
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            layer_pix_s = eff_on_s[i] ? layer_rgb[i*COLOR_W +: COLOR_W] : layer_pix_s;
        end
        if (visible_s) begin
            rgb_nxt_s = layer_pix_s;
        end else begin
            rgb_nxt_s = '0;
        end
    end

    // Pin registers load once per pixel and hold between ticks
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            rgb_r      <= '0;
            video_on_r <= 1'b0;
            hsync_r    <= 1'b1;
            vsync_r    <= 1'b1;
        end else if (pixel_tick_r) begin
            rgb_r      <= rgb_nxt_s;
            video_on_r <= visible_s;
            hsync_r    <= hsync_nxt_s;
            vsync_r    <= vsync_nxt_s;
        end else begin
            rgb_r      <= rgb_r;
            video_on_r <= video_on_r;
            hsync_r    <= hsync_r;
            vsync_r    <= vsync_r;
        end
    end

    assign pixel_x     = h_r;
    assign pixel_y     = v_r;
    assign pixel_tick  = pixel_tick_r;
    assign frame_start = frame_start_r;
    assign rgb         = rgb_r;
    assign video_on    = video_on_r;
    assign hsync       = hsync_r;
    assign vsync       = vsync_r;

endmodule

// File: tb/tb_vga_layer_compositor.sv
// Testbench for vga_layer_compositor, built on a shrunken raster
// (16x10 pixels, DIV=4, two-frame blink) so several frames fit in a short run.
// The expected pins come from the pixel index, which is counted from clock
// edges since reset release.
module tb_vga_layer_compositor;

    localparam int CW  = 3;
    localparam int NL  = 4;
    localparam int DIV = 4;
    localparam int HD = 8, HFP = 2, HS = 3, HBP = 3;
    localparam int VD = 6, VFP = 1, VS = 2, VBP = 1;
    localparam int BF = 2;
    localparam int HT = HD + HFP + HS + HBP;
    localparam int VT = VD + VFP + VS + VBP;
    localparam int FT = HT * VT;

    logic              clk = 1'b0;
    logic              reset;
    logic [NL-1:0]     layer_on;
    logic [NL*CW-1:0]  layer_rgb;
    logic [NL-1:0]     blink_en;
    logic [CW-1:0]     bg_rgb;
    logic [9:0]        pixel_x, pixel_y;
    logic              pixel_tick, frame_start, hsync, vsync, video_on;
    logic [CW-1:0]     rgb;

    vga_layer_compositor #(
        .COLOR_W(CW), .N_LAYERS(NL), .DIV(DIV),
        .H_DISPLAY(HD), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_DISPLAY(VD), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk_100MHz(clk), .reset(reset),
        .layer_on(layer_on), .layer_rgb(layer_rgb), .blink_en(blink_en), .bg_rgb(bg_rgb),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_tick(pixel_tick), .frame_start(frame_start),
        .hsync(hsync), .vsync(vsync), .video_on(video_on), .rgb(rgb)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          pix;
        logic [3:0]  on;
        logic [11:0] lrgb;
        logic [3:0]  ben;
        logic [2:0]  bg;
        logic [2:0]  e_rgb;
        logic        e_vid;
        logic        e_hs;
    } vec_t;

    localparam int NVEC = 12;
    vec_t tab [NVEC];
    logic [2:0] blink_exp [4];

    int n_err = 0;
    int n_chk = 0;
    int e;                 // rising edges since reset release
    int mode;              // 0 random, 1 directed table, 2 constant blink pattern
    int tab_idx;

    // values that the next tick edge samples
    logic [NL-1:0]    s_on;
    logic [NL*CW-1:0] s_lrgb;
    logic [NL-1:0]    s_ben;
    logic [CW-1:0]    s_bg;

    // expected pin state
    logic [CW-1:0] exp_rgb;
    logic          exp_vid, exp_hs, exp_vs;

    task automatic chk(input string nm, input int act, input int expv);
        n_chk++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", nm, act, expv, e, $time);
        end
    endtask

    function automatic logic [CW-1:0] ref_rgb(input int hh, input int vv, input int f,
                                              input logic [NL-1:0] on, input logic [NL*CW-1:0] lr,
                                              input logic [NL-1:0] be, input logic [CW-1:0] bg);
        logic          phase;
        logic [CW-1:0] r;
        bit            done;
        phase = ((f / BF) % 2) == 1;
        r = bg;
        done = 1'b0;
        if (hh >= HD || vv >= VD) begin
            r = '0;
        end else begin
            for (int i = 0; i < NL; i++) begin
                if (!done && on[i] && !(be[i] && phase)) begin
                    r = lr[i*CW +: CW];
                    done = 1'b1;
                end
            end
        end
        return r;
    endfunction

    task automatic reset_checks(input string tag);
        chk({tag, "_pixel_x"}, pixel_x, 0);
        chk({tag, "_pixel_y"}, pixel_y, 0);
        chk({tag, "_tick"}, pixel_tick, 0);
        chk({tag, "_frame_start"}, frame_start, 0);
        chk({tag, "_rgb"}, rgb, 0);
        chk({tag, "_video_on"}, video_on, 0);
        chk({tag, "_hsync"}, hsync, 1);
        chk({tag, "_vsync"}, vsync, 1);
    endtask

    task automatic restart_model();
        e = 0;
        exp_rgb = '0; exp_vid = 1'b0; exp_hs = 1'b1; exp_vs = 1'b1;
        tab_idx = -1;
        s_on = '0; s_lrgb = '0; s_ben = '0; s_bg = '0;
    endtask

    task automatic drive_random();
        layer_on  = 4'($urandom_range(15, 0));
        layer_rgb = 12'($urandom_range(4095, 0));
        blink_en  = 4'($urandom_range(15, 0));
        bg_rgb    = 3'($urandom_range(7, 0));
    endtask

    // one clock edge: check the outputs and the model, then drive the inputs
    task automatic step();
        int p, lp, hh, vv, f;
        bit tk;
        @(posedge clk);
        e++;
        #1;
        if (e % DIV == 0) begin
            lp = e / DIV - 1;
            hh = lp % HT;
            vv = (lp / HT) % VT;
            f  = lp / FT;
            exp_rgb = ref_rgb(hh, vv, f, s_on, s_lrgb, s_ben, s_bg);
            exp_vid = (hh < HD) && (vv < VD);
            exp_hs  = !((hh >= HD + HFP) && (hh < HD + HFP + HS));
            exp_vs  = !((vv >= VD + VFP) && (vv < VD + VFP + VS));
            if (tab_idx >= 0) begin
                chk("tab_rgb", rgb, tab[tab_idx].e_rgb);
                chk("tab_video_on", video_on, tab[tab_idx].e_vid);
                chk("tab_hsync", hsync, tab[tab_idx].e_hs);
                tab_idx = -1;
            end
            if (mode == 2 && (lp % FT) == HT + 1) begin
                chk("blink_rgb", rgb, blink_exp[f % 4]);
            end
        end
        p  = e / DIV;
        tk = ((e + 1) % DIV) == 0;
        chk("pixel_x", pixel_x, p % HT);
        chk("pixel_y", pixel_y, (p / HT) % VT);
        chk("pixel_tick", pixel_tick, tk);
        chk("frame_start", frame_start, tk && ((p % FT) == FT - 1));
        chk("rgb", rgb, exp_rgb);
        chk("video_on", video_on, exp_vid);
        chk("hsync", hsync, exp_hs);
        chk("vsync", vsync, exp_vs);
        if (tk) begin
            drive_random();
            if (mode == 1) begin
                for (int j = 0; j < NVEC; j++) begin
                    if (tab[j].pix == p) begin
                        layer_on  = tab[j].on;
                        layer_rgb = tab[j].lrgb;
                        blink_en  = tab[j].ben;
                        bg_rgb    = tab[j].bg;
                        tab_idx   = j;
                    end
                end
            end else if (mode == 2) begin
                layer_on  = 4'b0011;
                layer_rgb = {3'b000, 3'b000, 3'b011, 3'b101};
                blink_en  = 4'b0001;
                bg_rgb    = 3'b000;
            end
            s_on = layer_on; s_lrgb = layer_rgb; s_ben = blink_en; s_bg = bg_rgb;
        end else begin
            drive_random();   // must not reach the pins: only tick edges sample
        end
    endtask

    localparam logic [11:0] LSTD = {3'b011, 3'b010, 3'b100, 3'b111};

    initial begin
        tab[0]  = '{0,  4'b0110, LSTD, 4'b0000, 3'b001, 3'b100, 1'b1, 1'b1};
        tab[1]  = '{1,  4'b0000, LSTD, 4'b0000, 3'b001, 3'b001, 1'b1, 1'b1};
        tab[2]  = '{2,  4'b1111, LSTD, 4'b0000, 3'b001, 3'b111, 1'b1, 1'b1};
        tab[3]  = '{3,  4'b1000, LSTD, 4'b0000, 3'b001, 3'b011, 1'b1, 1'b1};
        tab[4]  = '{4,  4'b1100, {3'b011, 3'b110, 3'b100, 3'b111}, 4'b0000, 3'b001, 3'b110, 1'b1, 1'b1};
        tab[5]  = '{5,  4'b0001, LSTD, 4'b0001, 3'b001, 3'b111, 1'b1, 1'b1};
        tab[6]  = '{7,  4'b0000, LSTD, 4'b0000, 3'b110, 3'b110, 1'b1, 1'b1};
        tab[7]  = '{8,  4'b1111, LSTD, 4'b0000, 3'b110, 3'b000, 1'b0, 1'b1};
        tab[8]  = '{10, 4'b1111, LSTD, 4'b0000, 3'b110, 3'b000, 1'b0, 1'b0};
        tab[9]  = '{12, 4'b1111, LSTD, 4'b0000, 3'b110, 3'b000, 1'b0, 1'b0};
        tab[10] = '{13, 4'b1111, LSTD, 4'b0000, 3'b110, 3'b000, 1'b0, 1'b1};
        tab[11] = '{15, 4'b1111, LSTD, 4'b1111, 3'b110, 3'b000, 1'b0, 1'b1};
        blink_exp[0] = 3'b101; blink_exp[1] = 3'b101;
        blink_exp[2] = 3'b011; blink_exp[3] = 3'b011;

        reset = 1'b1;
        mode = 1;
        drive_random();
        restart_model();
        repeat (3) @(posedge clk);
        #1;
        reset_checks("por");
        reset = 1'b0;
        restart_model();

        // frame 0 directed table, then random frames spanning both blink phases
        while (e < FT * DIV) step();
        mode = 0;
        while (e < 6 * FT * DIV) step();

        // run into the sync corner (pixel_x=12, pixel_y=7), then reset mid-frame
        while (e != (6 * FT + 124) * DIV + 1) step();
        chk("pre_reset_hsync_low", hsync, 0);
        chk("pre_reset_vsync_low", vsync, 0);
        reset = 1'b1;
        #1;
        reset_checks("mid");
        repeat (2) @(posedge clk);
        #1;
        reset_checks("mid_held");
        reset = 1'b0;
        restart_model();
        mode = 2;

        // constant layers: layer 0 blinks over layer 1
        while (e < (8 * FT + 20) * DIV) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
